// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the seven-segment scan controller.
//   - SEG_0..SEG_9, SEG_BLANK, SEG_DASH: segment patterns, bit order {a,b,c,d,e,f,g,dp},
//     active-high, dp always 0.
//   - conv_state_e: state encoding of the shift-add-3 BCD converter.
//   - bcd_to_seg(): BCD nibble to segment pattern (non-decimal nibbles map to blank).
package seg_pkg;

   localparam logic [7:0] SEG_0     = 8'b1111_1100;
   localparam logic [7:0] SEG_1     = 8'b0110_0000;
   localparam logic [7:0] SEG_2     = 8'b1101_1010;
   localparam logic [7:0] SEG_3     = 8'b1111_0010;
   localparam logic [7:0] SEG_4     = 8'b0110_0110;
   localparam logic [7:0] SEG_5     = 8'b1011_0110;
   localparam logic [7:0] SEG_6     = 8'b1011_1110;
   localparam logic [7:0] SEG_7     = 8'b1110_0000;
   localparam logic [7:0] SEG_8     = 8'b1111_1110;
   localparam logic [7:0] SEG_9     = 8'b1110_0110;
   localparam logic [7:0] SEG_BLANK = 8'h00;
   localparam logic [7:0] SEG_DASH  = 8'b0000_0010;

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StDone
   } conv_state_e;

   function automatic logic [7:0] bcd_to_seg(input logic [3:0] nib);
      logic [7:0] seg;
      case (nib)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/bcd_shift_conv.sv
// bcd_shift_conv: sequential shift-add-3 (double dabble) binary-to-BCD converter.
// Converts a 9-bit and a 7-bit value in parallel over exactly 9 shift cycles.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   start                 - accepted only in IDLE; captures bin_a / bin_b
//   bin_a [8:0]           - first value (0-511), three BCD digits
//   bin_b [6:0]           - second value (0-99 meaningful), two BCD digits
//   busy                  - high from the capture edge until return to IDLE
//   done                  - high during the single DONE cycle; digits are final
//   a_hun/a_ten/a_one     - BCD digits of bin_a
//   b_ten/b_one           - BCD digits of bin_b (hundreds carry discarded)
module bcd_shift_conv
   import seg_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [8:0] bin_a,
   input  logic [6:0] bin_b,
   output logic       busy,
   output logic       done,
   output logic [3:0] a_hun,
   output logic [3:0] a_ten,
   output logic [3:0] a_one,
   output logic [3:0] b_ten,
   output logic [3:0] b_one
);

   conv_state_e state_q, state_d;
   logic [8:0]  sh_a_q, sh_a_d;
   logic [8:0]  sh_b_q, sh_b_d;
   logic [11:0] bcd_a_q, bcd_a_d;
   logic [7:0]  bcd_b_q, bcd_b_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        busy_q, busy_d;

   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   // Top nibble: its bit 3 would shift out of the accumulator, so only 3 bits are kept.
   function automatic logic [2:0] add3_lo(input logic [3:0] n);
      return (n >= 4'd5) ? 3'(n + 4'd3) : n[2:0];
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         sh_a_q  <= '0;
         sh_b_q  <= '0;
         bcd_a_q <= '0;
         bcd_b_q <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_a_q  <= sh_a_d;
         sh_b_q  <= sh_b_d;
         bcd_a_q <= bcd_a_d;
         bcd_b_q <= bcd_b_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sh_a_d  = sh_a_q;
      sh_b_d  = sh_b_q;
      bcd_a_d = bcd_a_q;
      bcd_b_d = bcd_b_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               sh_a_d  = bin_a;
               sh_b_d  = {2'b00, bin_b};
               bcd_a_d = '0;
               bcd_b_d = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = StShift;
            end
         end
         StShift: begin
            bcd_a_d = {add3_lo(bcd_a_q[11:8]), add3(bcd_a_q[7:4]), add3(bcd_a_q[3:0]),
                       sh_a_q[8]};
            bcd_b_d = {add3_lo(bcd_b_q[7:4]), add3(bcd_b_q[3:0]), sh_b_q[8]};
            sh_a_d  = {sh_a_q[7:0], 1'b0};
            sh_b_d  = {sh_b_q[7:0], 1'b0};
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd8) begin
               state_d = StDone;
            end
         end
         StDone: begin
            busy_d  = 1'b0;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign busy  = busy_q;
   assign done  = (state_q == StDone);
   assign a_hun = bcd_a_q[11:8];
   assign a_ten = bcd_a_q[7:4];
   assign a_one = bcd_a_q[3:0];
   assign b_ten = bcd_b_q[7:4];
   assign b_one = bcd_b_q[3:0];

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: eight-digit seven-segment scan controller.
// Snapshots menuState/seconds, converts them to BCD with bcd_shift_conv, commits the digits
// atomically and time-multiplexes them onto two segment buses (digits 1-4 and 5-8).
// Digits 2-4: menuState, digits 7-8: seconds (dash if >99), digits 1,5,6: blank.
// Optional feature macro: SEG_LEADING_ZERO_BLANK_EN blanks leading zeros of menuState.
// Ports:
//   clk, reset                - clock, asynchronous active-high reset
//   menuState [8:0]           - value shown on digits 2-4
//   seconds [6:0]             - value shown on digits 7-8
//   busy                      - BCD conversion in progress
//   tub_sel1..tub_sel8        - digit enables, active-high, two high per scan slot
//   tub_control1/2 [7:0]      - segment buses for digits 1-4 / 5-8, {a..g,dp}
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 100000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [8:0] menuState,
   input  logic [6:0] seconds,
   output logic       busy,
   output logic       tub_sel1,
   output logic       tub_sel2,
   output logic       tub_sel3,
   output logic       tub_sel4,
   output logic       tub_sel5,
   output logic       tub_sel6,
   output logic       tub_sel7,
   output logic       tub_sel8,
   output logic [7:0] tub_control1,
   output logic [7:0] tub_control2
);

   localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

   logic [8:0]    snap_menu_q;
   logic [6:0]    snap_sec_q;
   logic          snap_valid_q;
   logic          mismatch, start;
   logic          conv_busy, conv_done;
   logic [3:0]    a_hun, a_ten, a_one, b_ten, b_one;
   logic [7:0]    hun_seg, ten_seg, one_seg, sec_ten_seg, sec_one_seg;
   logic [7:0]    disp2_q, disp3_q, disp4_q, disp7_q, disp8_q;
   logic [PW-1:0] pre_q;
   logic [1:0]    slot_q;
   logic [7:0]    sel_d, sel_q;
   logic [7:0]    ctl1_d, ctl1_q, ctl2_d, ctl2_q;

   // Change detection only while the converter is idle; mid-conversion changes are picked
   // up by the compare that follows DONE.
   assign mismatch = !snap_valid_q || ({menuState, seconds} != {snap_menu_q, snap_sec_q});
   assign start    = !conv_busy && mismatch;

   bcd_shift_conv u_conv (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .bin_a (menuState),
      .bin_b (seconds),
      .busy  (conv_busy),
      .done  (conv_done),
      .a_hun (a_hun),
      .a_ten (a_ten),
      .a_one (a_one),
      .b_ten (b_ten),
      .b_one (b_one)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         snap_menu_q  <= '0;
         snap_sec_q   <= '0;
         snap_valid_q <= 1'b0;
      end else begin
         if (start) begin
            snap_menu_q <= menuState;
            snap_sec_q  <= seconds;
         end
         if (conv_done) begin
            snap_valid_q <= 1'b1;
         end
      end
   end

   always_comb begin
      hun_seg     = bcd_to_seg(a_hun);
      ten_seg     = bcd_to_seg(a_ten);
      one_seg     = bcd_to_seg(a_one);
      sec_ten_seg = bcd_to_seg(b_ten);
      sec_one_seg = bcd_to_seg(b_one);
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if (a_hun == 4'd0) begin
         hun_seg = SEG_BLANK;
         if (a_ten == 4'd0) begin
            ten_seg = SEG_BLANK;
         end
      end
`endif
      // The converter drops the seconds hundreds carry, so range is judged on the snapshot.
      if (snap_sec_q > 7'd99) begin
         sec_ten_seg = SEG_DASH;
         sec_one_seg = SEG_DASH;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         disp2_q <= SEG_BLANK;
         disp3_q <= SEG_BLANK;
         disp4_q <= SEG_BLANK;
         disp7_q <= SEG_BLANK;
         disp8_q <= SEG_BLANK;
      end else if (conv_done) begin
         disp2_q <= hun_seg;
         disp3_q <= ten_seg;
         disp4_q <= one_seg;
         disp7_q <= sec_ten_seg;
         disp8_q <= sec_one_seg;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_q  <= '0;
         slot_q <= '0;
      end else if (pre_q == PRE_LAST) begin
         pre_q  <= '0;
         slot_q <= slot_q + 2'd1;
      end else begin
         pre_q  <= pre_q + 1'b1;
      end
   end

   always_comb begin
      sel_d  = 8'h11 << slot_q;
      ctl1_d = SEG_BLANK;
      ctl2_d = SEG_BLANK;
      unique case (slot_q)
         2'd0: begin ctl1_d = SEG_BLANK; ctl2_d = SEG_BLANK; end
         2'd1: begin ctl1_d = disp2_q;   ctl2_d = SEG_BLANK; end
         2'd2: begin ctl1_d = disp3_q;   ctl2_d = disp7_q;   end
         2'd3: begin ctl1_d = disp4_q;   ctl2_d = disp8_q;   end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sel_q  <= '0;
         ctl1_q <= SEG_BLANK;
         ctl2_q <= SEG_BLANK;
      end else begin
         sel_q  <= sel_d;
         ctl1_q <= ctl1_d;
         ctl2_q <= ctl2_d;
      end
   end

   assign busy         = conv_busy;
   assign tub_sel1     = sel_q[0];
   assign tub_sel2     = sel_q[1];
   assign tub_sel3     = sel_q[2];
   assign tub_sel4     = sel_q[3];
   assign tub_sel5     = sel_q[4];
   assign tub_sel6     = sel_q[5];
   assign tub_sel7     = sel_q[6];
   assign tub_sel8     = sel_q[7];
   assign tub_control1 = ctl1_q;
   assign tub_control2 = ctl2_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl with SCAN_DIV=4. Expected digit patterns are pushed to a
// queue when inputs are driven and popped once a full scan of the display has been captured.
module tb_seg_scan_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [8:0] menuState;
   logic [6:0] seconds;
   logic       busy;
   logic       tub_sel1, tub_sel2, tub_sel3, tub_sel4;
   logic       tub_sel5, tub_sel6, tub_sel7, tub_sel8;
   logic [7:0] tub_control1, tub_control2;
   logic [7:0] sel;

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];

   assign sel = {tub_sel8, tub_sel7, tub_sel6, tub_sel5, tub_sel4, tub_sel3, tub_sel2, tub_sel1};

   seg_scan_ctrl #(.SCAN_DIV(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .menuState    (menuState),
      .seconds      (seconds),
      .busy         (busy),
      .tub_sel1     (tub_sel1),
      .tub_sel2     (tub_sel2),
      .tub_sel3     (tub_sel3),
      .tub_sel4     (tub_sel4),
      .tub_sel5     (tub_sel5),
      .tub_sel6     (tub_sel6),
      .tub_sel7     (tub_sel7),
      .tub_sel8     (tub_sel8),
      .tub_control1 (tub_control1),
      .tub_control2 (tub_control2)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] seg_of(input int d);
      logic [7:0] tbl [10];
      tbl = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hE6};
      return tbl[d];
   endfunction

   task automatic push_expected(input int m, input int s);
      logic [7:0] d2, d3, d4, d7, d8;
      d2 = seg_of(m / 100);
      d3 = seg_of((m / 10) % 10);
      d4 = seg_of(m % 10);
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if (m < 100) d2 = 8'h00;
      if (m < 10)  d3 = 8'h00;
`endif
      if (s > 99) begin
         d7 = 8'h02;
         d8 = 8'h02;
      end else begin
         d7 = seg_of(s / 10);
         d8 = seg_of(s % 10);
      end
      exp_q.push_back(8'h00);
      exp_q.push_back(d2);
      exp_q.push_back(d3);
      exp_q.push_back(d4);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h00);
      exp_q.push_back(d7);
      exp_q.push_back(d8);
   endtask

   task automatic wait_conv(input string tag);
      int i;
      i = 0;
      while (!busy && i < 4) begin
         @(posedge clk); #1;
         i++;
      end
      check({tag, "_busy_rise"}, busy, 1);
      i = 0;
      while (busy && i < 20) begin
         @(posedge clk); #1;
         i++;
      end
      check({tag, "_busy_fall"}, busy, 0);
   endtask

   // Captures one full scan (4 slots x 4 cycles) and compares against queued expectations.
   task automatic scan_check(input string tag);
      logic [7:0] cap [8];
      logic [7:0] e;
      for (int i = 0; i < 8; i++) cap[i] = 8'hFF;
      for (int c = 0; c < 16; c++) begin
         @(posedge clk); #1;
         check({tag, "_nsel"}, $countones(sel), 2);
         for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
               cap[i]     = tub_control1;
               cap[i + 4] = tub_control2;
            end
         end
      end
      for (int d = 0; d < 8; d++) begin
         if (exp_q.size() == 0) begin
            check($sformatf("%s_q_empty_d%0d", tag, d + 1), 0, 1);
         end else begin
            e = exp_q.pop_front();
            check($sformatf("%s_d%0d", tag, d + 1), cap[d], e);
         end
      end
   endtask

   initial begin
      int rises;
      logic prev;
      logic [7:0] exp_d4;

      reset     = 1'b1;
      menuState = 9'd42;
      seconds   = 7'd7;
      push_expected(42, 7);
      repeat (2) @(posedge clk);
      #1;
      check("rst_sel", sel, 0);
      check("rst_ctl1", tub_control1, 0);
      check("rst_ctl2", tub_control2, 0);
      check("rst_busy", busy, 0);
      #4 reset = 1'b0;

      // Scan order and conversion latency from reset release.
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk); #1;
         check($sformatf("scan_sel_%0d", n), sel, 8'h11 << (((n - 1) / 4) % 4));
         if (n == 1) begin
            check("first_busy", busy, 1);
            check("first_ctl1", tub_control1, 0);
            check("first_ctl2", tub_control2, 0);
         end
         if (n == 10) check("busy_at_10", busy, 1);
         if (n == 11) check("busy_at_11", busy, 0);
      end
      scan_check("t42_7");

      menuState = 9'd511;
      seconds   = 7'd99;
      push_expected(511, 99);
      wait_conv("t511");
      scan_check("t511_99");

      menuState = 9'd300;
      seconds   = 7'd120;
      push_expected(300, 120);
      wait_conv("t300");
      scan_check("t300_120");

      // Input change during SHIFT: 3 is committed first, then 8.
      menuState = 9'd3;
      seconds   = 7'd12;
      push_expected(8, 12);
      @(posedge clk); #1;
      check("t38_cap", busy, 1);
      prev  = 1'b1;
      rises = 1;
      for (int e = 1; e <= 40; e++) begin
         if (e == 4) menuState = 9'd8;
         @(posedge clk); #1;
         if (busy && !prev) rises++;
         prev = busy;
         if (e == 10) check("t38_busy_fall1", busy, 0);
         if (e == 11) check("t38_busy_rise2", busy, 1);
         if (tub_sel4) begin
            exp_d4 = (e <= 10) ? seg_of(0) : (e <= 21) ? seg_of(3) : seg_of(8);
            check($sformatf("t38_d4_e%0d", e), tub_control1, exp_d4);
         end
      end
      check("t38_busy_pulses", rises, 2);
      scan_check("t38");

      // Reset in the middle of SHIFT.
      menuState = 9'd123;
      seconds   = 7'd45;
      push_expected(123, 45);
      @(posedge clk); #1;
      repeat (4) begin
         @(posedge clk); #1;
      end
      #2 reset = 1'b1;
      #1;
      check("mid_rst_sel", sel, 0);
      check("mid_rst_ctl1", tub_control1, 0);
      check("mid_rst_ctl2", tub_control2, 0);
      check("mid_rst_busy", busy, 0);
      #2 reset = 1'b0;
      wait_conv("t123");
      scan_check("t123_45");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Scan controller for the eight-digit seven-segment display. It snapshots `menuState` and `seconds`, converts them to BCD with a sequential shift-add-3 engine, and time-multiplexes the result onto both segment buses.
- Digits 2-4 show `menuState` (0-511).
- Digits 7-8 show `seconds`.
- Digits 1, 5 and 6 are blank.

It sits between the menu/timer logic and the board pins, and replaces any direct static drive of `tub_sel*`/`tub_control*`.

## Interface
Parameters:
- `SCAN_DIV`, default 100000: clock cycles per scan slot (1 kHz slot rate at 100 MHz).

Ports:
- `clk` input 1: system clock; all logic on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `menuState` input 9: menu state code, shown in decimal.
- `seconds` input 7: timer value; valid range 0-99.
- `busy` output 1: high while a BCD conversion is in progress.
- `tub_sel1`..`tub_sel8` output 1 each: digit enables, active-high, numbered from the left.
- `tub_control1` output 8: segment bus for digits 1-4, bit order {a,b,c,d,e,f,g,dp}, active-high.
- `tub_control2` output 8: segment bus for digits 5-8, same encoding.

## Operation
- Converter FSM states: IDLE, SHIFT, DONE.
- **IDLE:** a mismatch exists if `snap_valid`=0, or `{menuState,seconds}` differs from the snapshot. On a mismatch:
  - capture both inputs into the snapshot and the shift registers;
  - clear the BCD accumulators and the shift counter;
  - go to SHIFT.
- **SHIFT:** exactly 9 cycles. Each cycle:
  - add 3 to every BCD nibble ≥5;
  - shift left by one.
  - `menuState` feeds 3 nibbles (hundreds/tens/units).
  - `seconds` is zero-extended to 9 bits and feeds 2 nibbles. The seconds hundreds carry is discarded; inputs ≤99 never produce one.
  - After the 9th shift, go to DONE.
- **DONE:** one cycle.
  - Commit all five digits to the display registers atomically.
  - Set `snap_valid`; return to IDLE.
- **Out of range:** if the captured `seconds` >99, digits 7-8 show dash (g only, 8'b00000010).
- **Inputs changing during SHIFT/DONE:** ignored. The IDLE compare after DONE starts a fresh conversion with the latest values.
- **Scan:**
  - Prescaler counts 0..`SCAN_DIV`-1. At terminal count it wraps to 0, and the slot index advances 0→1→2→3→0.
  - Slot i asserts `tub_sel(i+1)` and `tub_sel(i+5)`; exactly two enables are high.
  - `tub_control1` carries the digit i+1 pattern; `tub_control2` carries digit i+5.
  - Scanning never stalls for conversion; it always shows the last committed display registers.
- **Digit encoding:**
  - Blank = 8'h00.
  - Digits 0-9 use the standard patterns (0=11111100 … 9=11100110).
  - dp is always 0.

## Timing
- Reset (asynchronous, while `reset`=1):
  - all `tub_sel*` = 0;
  - `tub_control1`/`tub_control2` = 8'h00;
  - `busy` = 0;
  - FSM = IDLE, `snap_valid` = 0;
  - prescaler = 0, slot = 0;
  - display registers = blank.
- First clock edge after reset release: outputs are driven for slot 0 (`tub_sel1`, `tub_sel5` high, blank patterns).
- Conversion captured at edge k: SHIFT on edges k+1..k+9, commit at edge k+10.
  - `busy` is high from after edge k until edge k+10.
- New digit values appear on the segment outputs at the first registered output update after k+10 in which their slot is active. Worst case is 4·`SCAN_DIV` cycles later.
- All outputs are registered; there are no combinational paths from input to output.
- Reset asserted mid-conversion: abort immediately; the display returns to blank.

## Configuration
- `SEG_LEADING_ZERO_BLANK_EN`
  - Defined: leading zeros of `menuState` are blanked (7 shows as blank, blank, blank, 7). Units digit always shown. Seconds always show two digits.
  - Undefined: `menuState` always shows three digits with zeros (007).

## Structure
- Shared package `seg_pkg` holds:
  - `SEG_0`..`SEG_9`, `SEG_BLANK`, `SEG_DASH`;
  - the FSM state encoding;
  - the BCD-nibble-to-segment function.
- Sub-module `bcd_shift_conv`:
  - holds the IDLE/SHIFT/DONE engine;
  - start/busy/done interface;
  - 9-bit and 7-bit inputs, five BCD nibble outputs.
- Top level holds change detection, display registers, prescaler, slot counter and output registers.

## Test plan
- Reset, then hold `menuState`=42, `seconds`=7: after 11 cycles `busy` falls; slot patterns are digit 3=`SEG_4`, digit 4=`SEG_2`, digit 7=`SEG_0`, digit 8=`SEG_7`. Digit 2 is blank with the macro, `SEG_0` without.
- `SCAN_DIV`=4, run 20 cycles: `tub_sel` pairs (1,5),(2,6),(3,7),(4,8) each held 4 cycles, then wrap to (1,5); never more than two enables high.
- `menuState`=511, `seconds`=99: digits read 5,1,1 and 9,9.
- `seconds`=120: digits 7-8 = `SEG_DASH`.
- Change `menuState` 3→8 during cycle 4 of SHIFT: the first commit shows 3; a second conversion starts in the IDLE cycle; final display shows 8; `busy` pulses twice.
- Assert `reset` mid-SHIFT: all outputs 0 asynchronously; after release, a full conversion reruns and the display is restored.
